// File: rtl/gost89_cfb_decrypt.sv
// gost89_cfb_decrypt: GOST 28147-89 cipher-feedback (CFB) decryptor.
// A single-round core iterates 32 cycles per 64-bit block. The keystream
// for block i is E_K(C(i-1)), and the chained value is the received
// ciphertext, so C(0) = IV.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, dominates all inputs
//   load_data  start strobe, sampled only while idle
//   load_IV    with load_data: feedback := IV before the block
//   key        256-bit key, K_j = key[255-32j -: 32]; hold while busy
//   in         64-bit ciphertext block, captured on the accepted load
//   IV         64-bit initialisation vector
//   sbox       (only with GOST89_CFB_SBOX_PORT_EN) S_k[v] = sbox[64k+4v +: 4]
//   out        64-bit plaintext, updated only on completion or reset
//   busy       high while rounds are in progress
//
// Build option: define GOST89_CFB_SBOX_PORT_EN to take the S-boxes from
// the sbox port. Otherwise the id-GostR3411-94-TestParamSet table is fixed.
module gost89_cfb_decrypt (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_data,
  input  logic         load_IV,
  input  logic [255:0] key,
  input  logic [63:0]  in,
  input  logic [63:0]  IV,
`ifdef GOST89_CFB_SBOX_PORT_EN
  input  logic [511:0] sbox,
`endif
  output logic [63:0]  out,
  output logic         busy
);

`ifndef GOST89_CFB_SBOX_PORT_EN
  localparam logic [3:0] SBOX [8][16] = '{
    '{4'h4, 4'ha, 4'h9, 4'h2, 4'hd, 4'h8, 4'h0, 4'he, 4'h6, 4'hb, 4'h1, 4'hc, 4'h7, 4'hf, 4'h5, 4'h3},
    '{4'he, 4'hb, 4'h4, 4'hc, 4'h6, 4'hd, 4'hf, 4'ha, 4'h2, 4'h3, 4'h8, 4'h1, 4'h0, 4'h7, 4'h5, 4'h9},
    '{4'h5, 4'h8, 4'h1, 4'hd, 4'ha, 4'h3, 4'h4, 4'h2, 4'he, 4'hf, 4'hc, 4'h7, 4'h6, 4'h0, 4'h9, 4'hb},
    '{4'h7, 4'hd, 4'ha, 4'h1, 4'h0, 4'h8, 4'h9, 4'hf, 4'he, 4'h4, 4'h6, 4'hc, 4'hb, 4'h2, 4'h5, 4'h3},
    '{4'h6, 4'hc, 4'h7, 4'h1, 4'h5, 4'hf, 4'hd, 4'h8, 4'h4, 4'ha, 4'h9, 4'he, 4'h0, 4'h3, 4'hb, 4'h2},
    '{4'h4, 4'hb, 4'ha, 4'h0, 4'h7, 4'h2, 4'h1, 4'hd, 4'h3, 4'h6, 4'h8, 4'h5, 4'h9, 4'hc, 4'hf, 4'he},
    '{4'hd, 4'hb, 4'h4, 4'h1, 4'h3, 4'hf, 4'h5, 4'h9, 4'h0, 4'ha, 4'he, 4'h7, 4'h6, 4'h8, 4'h2, 4'hc},
    '{4'h1, 4'hf, 4'hd, 4'h0, 4'h5, 4'h7, 4'ha, 4'h4, 4'h9, 4'h2, 4'h3, 4'he, 4'h6, 4'hb, 4'h8, 4'hc}
  };
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [63:0] fb_q, ct_q, out_q;
  logic [31:0] n1_q, n2_q;
  logic [4:0]  rnd_q;
  logic        start, last;

  logic [2:0]  kpos;
  logic [31:0] subkey, t, s, res;
  logic [63:0] x;

  // Encryption schedule: K0..K7 three times, then K7..K0. K_j sits at
  // word position 7-j of the key vector, hence the inverted index.
  assign kpos   = (rnd_q < 5'd24) ? ~rnd_q[2:0] : rnd_q[2:0];
  assign subkey = key[{kpos, 5'b00000} +: 32];
  assign x      = load_IV ? IV : fb_q;

  always_comb begin
    t = n1_q + subkey;
    s = '0;
    for (int k = 0; k < 8; k++) begin
`ifdef GOST89_CFB_SBOX_PORT_EN
      s[4*k +: 4] = sbox[64*k + 4*int'(t[4*k +: 4]) +: 4];
`else
      s[4*k +: 4] = SBOX[k][t[4*k +: 4]];
`endif
    end
    res = {s[20:0], s[31:21]} ^ n2_q;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (load_data) begin
        start   = 1'b1;
        state_d = RUN;
      end
      RUN: if (rnd_q == 5'd31) begin
        last    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fb_q    <= '0;
      ct_q    <= '0;
      out_q   <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        ct_q  <= in;
        if (load_IV) fb_q <= IV;
        n1_q  <= x[31:0];
        n2_q  <= x[63:32];
        rnd_q <= '0;
      end else if (state_q == RUN) begin
        rnd_q <= rnd_q + 5'd1;
        if (last) begin
          // No final swap: gamma is {result, N1}.
          n2_q  <= res;
          out_q <= {res, n1_q} ^ ct_q;
          fb_q  <= ct_q;
        end else begin
          n2_q <= n1_q;
          n1_q <= res;
        end
      end
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_gost89_cfb_decrypt.sv
// Self-checking bench for gost89_cfb_decrypt: directed steps, a scoreboard
// queue of expected plaintexts and an independent GOST 28147-89 model.
module tb_gost89_cfb_decrypt;
  logic         clk = 1'b0;
  logic         reset, load_data, load_IV;
  logic [255:0] key;
  logic [63:0]  in_blk, iv, out;
  logic         busy;
`ifdef GOST89_CFB_SBOX_PORT_EN
  logic [511:0] sbox;
`endif

  always #5 clk = ~clk;

  gost89_cfb_decrypt dut (
    .clk       (clk),
    .reset     (reset),
    .load_data (load_data),
    .load_IV   (load_IV),
    .key       (key),
    .in        (in_blk),
    .IV        (iv),
`ifdef GOST89_CFB_SBOX_PORT_EN
    .sbox      (sbox),
`endif
    .out       (out),
    .busy      (busy)
  );

  localparam logic [3:0] TBL [8][16] = '{
    '{4'h4, 4'ha, 4'h9, 4'h2, 4'hd, 4'h8, 4'h0, 4'he, 4'h6, 4'hb, 4'h1, 4'hc, 4'h7, 4'hf, 4'h5, 4'h3},
    '{4'he, 4'hb, 4'h4, 4'hc, 4'h6, 4'hd, 4'hf, 4'ha, 4'h2, 4'h3, 4'h8, 4'h1, 4'h0, 4'h7, 4'h5, 4'h9},
    '{4'h5, 4'h8, 4'h1, 4'hd, 4'ha, 4'h3, 4'h4, 4'h2, 4'he, 4'hf, 4'hc, 4'h7, 4'h6, 4'h0, 4'h9, 4'hb},
    '{4'h7, 4'hd, 4'ha, 4'h1, 4'h0, 4'h8, 4'h9, 4'hf, 4'he, 4'h4, 4'h6, 4'hc, 4'hb, 4'h2, 4'h5, 4'h3},
    '{4'h6, 4'hc, 4'h7, 4'h1, 4'h5, 4'hf, 4'hd, 4'h8, 4'h4, 4'ha, 4'h9, 4'he, 4'h0, 4'h3, 4'hb, 4'h2},
    '{4'h4, 4'hb, 4'ha, 4'h0, 4'h7, 4'h2, 4'h1, 4'hd, 4'h3, 4'h6, 4'h8, 4'h5, 4'h9, 4'hc, 4'hf, 4'he},
    '{4'hd, 4'hb, 4'h4, 4'h1, 4'h3, 4'hf, 4'h5, 4'h9, 4'h0, 4'ha, 4'he, 4'h7, 4'h6, 4'h8, 4'h2, 4'hc},
    '{4'h1, 4'hf, 4'hd, 4'h0, 4'h5, 4'h7, 4'ha, 4'h4, 4'h9, 4'h2, 4'h3, 4'he, 4'h6, 4'hb, 4'h8, 4'hc}
  };

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q [$];
  logic [63:0] fb_m;

  // Reference model: textbook 32-round Feistel with swap each round,
  // the last swap undone when forming the output.
  function automatic logic [31:0] g_fn(input logic [31:0] a);
    logic [31:0] s;
    for (int k = 0; k < 8; k++) s[4*k +: 4] = TBL[k][a[4*k +: 4]];
    return (s << 11) | (s >> 21);
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] blk);
    logic [31:0] a, b, tmp, kk;
    int j;
    a = blk[31:0];
    b = blk[63:32];
    for (int i = 0; i < 32; i++) begin
      j   = (i < 24) ? (i % 8) : (7 - (i % 8));
      kk  = key[255 - 32*j -: 32];
      tmp = b ^ g_fn(a + kk);
      b   = a;
      a   = tmp;
    end
    return {a, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive a load for one cycle at a negedge; scoreboard the plaintext.
  task automatic start(input logic [63:0] c, input logic [63:0] v, input logic liv);
    logic [63:0] xin;
    in_blk = c; iv = v; load_IV = liv; load_data = 1'b1;
    xin = liv ? v : fb_m;
    exp_q.push_back(c ^ enc(xin));
    fb_m = c;
    @(negedge clk);
    load_data = 1'b0; load_IV = 1'b0;
  endtask

  // Wait out a block; optionally pulse load_data at busy cycle inj_at.
  task automatic wait_block(input string tag, input int inj_at, input logic [63:0] inj);
    int          cnt;
    logic [63:0] o0, stable, popped;
    cnt = 0; o0 = out; stable = 64'd1;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (out !== o0) stable = 64'd0;
      if (cnt == inj_at) begin in_blk = inj; load_data = 1'b1; end
      else load_data = 1'b0;
      @(negedge clk);
    end
    load_data = 1'b0;
    check({tag, " busy_cycles"}, 64'(cnt), 64'd32);
    check({tag, " out_stable"}, stable, 64'd1);
    if (exp_q.size() == 0) check({tag, " scoreboard_empty"}, 64'd0, 64'd1);
    else begin
      popped = exp_q.pop_front();
      check({tag, " out"}, out, popped);
    end
  endtask

  initial begin
    logic [63:0] p;
    key = 256'h0475f6e05038fbfad2c7c390edb3ca3d1547124291ae1e8a2f79cd9ed2bcefbd;
`ifdef GOST89_CFB_SBOX_PORT_EN
    for (int k = 0; k < 8; k++)
      for (int v = 0; v < 16; v++) sbox[64*k + 4*v +: 4] = TBL[k][v];
`endif
    reset = 1'b1; load_data = 1'b0; load_IV = 1'b0; in_blk = '0; iv = '0;
    fb_m = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset out", out, 64'h0);
    check("reset busy", 64'(busy), 64'd0);

    // Single block from IV: out = E_K(IV) since ct = 0.
    start(64'h0, 64'hd5a8a608f4f115b4, 1'b1);
    wait_block("blk1", 0, 64'h0);

    // Chaining without IV: gamma from fb = previous ct (0).
    start(64'h389eb44a391474c4, 64'h0, 1'b0);
    wait_block("chain", 0, 64'h0);
    p = out;
    check("loopback", p ^ enc(64'h0), 64'h389eb44a391474c4);

    // Reset on busy cycle 7 abandons the block.
    start(64'h1122334455667788, 64'hcafef00ddeadbeef, 1'b1);
    exp_q.delete();
    repeat (6) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fb_m = '0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset out", out, 64'h0);

    // Load after reset without IV uses fb = 0; stray load at busy cycle 10.
    start(64'hfedcba9876543210, 64'h0, 1'b0);
    wait_block("busyload", 10, 64'h0123456789abcdef);
    @(negedge clk);
    check("no restart busy", 64'(busy), 64'd0);
    // fb must be the original ct, not the ignored word.
    start(64'h0, 64'h0, 1'b0);
    wait_block("fbchk", 0, 64'h0);

    // Reset together with load: nothing captured.
    reset = 1'b1; load_data = 1'b1; in_blk = 64'h3f38ae3b8f541361;
    @(negedge clk);
    reset = 1'b0; load_data = 1'b0;
    fb_m = '0;
    check("rstload busy", 64'(busy), 64'd0);
    check("rstload out", out, 64'h0);
    @(negedge clk);
    check("rstload busy2", 64'(busy), 64'd0);
    start(64'h0badc0de12345678, 64'h0, 1'b0);
    wait_block("afterrst", 0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
